// File: rtl/regfile_pkg.sv
// Shared definitions for the register file scoreboard: NZP bit layout,
// reset value and the condition-code helper.
package regfile_pkg;
  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;
  localparam logic [2:0] NZP_RESET = 3'b010;
  localparam int MAX_W = 64;

  // Caller sign-extends its DATA_W-bit value to MAX_W bits; sign extension
  // preserves both zero-ness and the sign bit, so one function serves any DATA_W.
  function automatic logic [2:0] nzp_of(input logic [MAX_W-1:0] data);
    logic [2:0] r;
    r = '0;
    if (data == '0)         r[NZP_Z] = 1'b1;
    else if (data[MAX_W-1]) r[NZP_N] = 1'b1;
    else                    r[NZP_P] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: select mux, optional write bypass, and
// pending-bit qualification.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [NREGS-1:0]             pending,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_sel,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [AW-1:0]                sel,
  output logic [DATA_W-1:0]            data,
  output logic                         busy
);
  logic hit;

  assign hit  = (BYPASS != 0) && wr_en && (wr_sel == sel);
  assign data = hit ? wr_data : regs[sel];
  // The clearing write satisfies the reservation only when it is forwarded.
  assign busy = pending[sel] & ~hit;
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard and NZP
// condition codes updated on writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Wr_En,
  input  logic [AW-1:0]         i_Wr_Sel,
  input  logic [DATA_W-1:0]     i_Wr_Data,
  input  logic                  i_Ld_CC,
  input  logic                  i_Rsv_En,
  input  logic [AW-1:0]         i_Rsv_Sel,
  input  logic [NRD*AW-1:0]     i_Rd_Sel,
  output logic [NRD*DATA_W-1:0] o_Rd_Data,
  output logic [NRD-1:0]        o_Rd_Busy,
  output logic [2:0]            o_NZP,
  output logic                  o_Any_Busy
);
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             pending, pending_nxt;
  logic signed [DATA_W-1:0]     wr_s;

  assign wr_s = i_Wr_Data;

  // Reserve is applied after the clear so it wins on a same-register collision.
  always_comb begin
    pending_nxt = pending;
    if (i_Wr_En)  pending_nxt[i_Wr_Sel]  = 1'b0;
    if (i_Rsv_En) pending_nxt[i_Rsv_Sel] = 1'b1;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      regs    <= '0;
      pending <= '0;
      o_NZP   <= NZP_RESET;
    end else begin
      if (i_Wr_En) regs[i_Wr_Sel] <= i_Wr_Data;
      pending <= pending_nxt;
      if (i_Wr_En && i_Ld_CC) o_NZP <= nzp_of(MAX_W'(wr_s));
    end
  end

  assign o_Any_Busy = |pending;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W(DATA_W),
      .NREGS (NREGS),
      .BYPASS(BYPASS)
    ) u_port (
      .regs   (regs),
      .pending(pending),
      .wr_en  (i_Wr_En),
      .wr_sel (i_Wr_Sel),
      .wr_data(i_Wr_Data),
      .sel    (i_Rd_Sel[k*AW +: AW]),
      .data   (o_Rd_Data[k*DATA_W +: DATA_W]),
      .busy   (o_Rd_Busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: bypass and non-bypass instances share one
// vector table; a wide three-port instance covers the parameter sweep.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_en = 0, ld_cc = 0, rsv_en = 0;
  logic [2:0]  wr_sel = 0, rsv_sel = 0;
  logic [15:0] wr_data = 0;
  logic [5:0]  rd_sel = 0;
  logic [31:0] rd_b, rd_n;
  logic [1:0]  busy_b, busy_n;
  logic [2:0]  nzp_b, nzp_n;
  logic        any_b, any_n;

  logic        w_wr_en = 0, w_ld_cc = 0, w_rsv_en = 0;
  logic [3:0]  w_wr_sel = 0, w_rsv_sel = 0;
  logic [31:0] w_wr_data = 0;
  logic [11:0] w_rd_sel = 0;
  logic [95:0] w_rd;
  logic [2:0]  w_busy, w_nzp;
  logic        w_any;

  regfile_scoreboard #(.DATA_W(16), .NREGS(8), .NRD(2), .BYPASS(1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_En(wr_en), .i_Wr_Sel(wr_sel), .i_Wr_Data(wr_data),
    .i_Ld_CC(ld_cc), .i_Rsv_En(rsv_en), .i_Rsv_Sel(rsv_sel), .i_Rd_Sel(rd_sel),
    .o_Rd_Data(rd_b), .o_Rd_Busy(busy_b), .o_NZP(nzp_b), .o_Any_Busy(any_b));

  regfile_scoreboard #(.DATA_W(16), .NREGS(8), .NRD(2), .BYPASS(0)) dut_nb (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_En(wr_en), .i_Wr_Sel(wr_sel), .i_Wr_Data(wr_data),
    .i_Ld_CC(ld_cc), .i_Rsv_En(rsv_en), .i_Rsv_Sel(rsv_sel), .i_Rd_Sel(rd_sel),
    .o_Rd_Data(rd_n), .o_Rd_Busy(busy_n), .o_NZP(nzp_n), .o_Any_Busy(any_n));

  regfile_scoreboard #(.DATA_W(32), .NREGS(16), .NRD(3), .BYPASS(1)) dut_w (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_En(w_wr_en), .i_Wr_Sel(w_wr_sel), .i_Wr_Data(w_wr_data),
    .i_Ld_CC(w_ld_cc), .i_Rsv_En(w_rsv_en), .i_Rsv_Sel(w_rsv_sel), .i_Rd_Sel(w_rd_sel),
    .o_Rd_Data(w_rd), .o_Rd_Busy(w_busy), .o_NZP(w_nzp), .o_Any_Busy(w_any));

  typedef struct packed {
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        ld_cc;
    logic        rsv_en;
    logic [2:0]  rsv_sel;
    logic [2:0]  rd0, rd1;
    logic [15:0] b0, b1;   // bypass instance read data
    logic [1:0]  bb;
    logic [15:0] n0, n1;   // non-bypass instance read data
    logic [1:0]  nb;
    logic [2:0]  nzp;      // after the edge
    logic        any;
  } vec_t;

  typedef struct packed {
    logic [2:0] nzp;
    logic       any;
  } exp_t;

  vec_t vecs[15];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input logic we, input logic [2:0] ws, input logic [15:0] wd, input logic cc,
    input logic re, input logic [2:0] rs, input logic [2:0] r0, input logic [2:0] r1,
    input logic [15:0] b0, input logic [15:0] b1, input logic [1:0] bb,
    input logic [15:0] n0, input logic [15:0] n1, input logic [1:0] nb,
    input logic [2:0] nzp, input logic any);
    vec_t v;
    v = '{we, ws, wd, cc, re, rs, r0, r1, b0, b1, bb, n0, n1, nb, nzp, any};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vec_t v;
    //            we ws wd       cc re rs r0 r1  b0       b1       bb     n0       n1       nb     nzp     any
    vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 7, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 3'b010, 0);
    vecs[1]  = mk(1, 3, 16'h8001, 1, 0, 0, 3, 0, 16'h8001, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 3'b100, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 0, 0, 3, 3, 16'h8001, 16'h8001, 2'b00, 16'h8001, 16'h8001, 2'b00, 3'b100, 0);
    vecs[3]  = mk(1, 5, 16'h0000, 1, 0, 0, 5, 3, 16'h0000, 16'h8001, 2'b00, 16'h0000, 16'h8001, 2'b00, 3'b010, 0);
    vecs[4]  = mk(1, 1, 16'h0042, 0, 0, 0, 1, 5, 16'h0042, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 3'b010, 0);
    vecs[5]  = mk(1, 2, 16'h1234, 0, 0, 0, 2, 2, 16'h1234, 16'h1234, 2'b00, 16'h0000, 16'h0000, 2'b00, 3'b010, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 0, 2, 1, 16'h1234, 16'h0042, 2'b00, 16'h1234, 16'h0042, 2'b00, 3'b010, 0);
    vecs[7]  = mk(0, 0, 16'h8000, 1, 0, 0, 0, 1, 16'h0000, 16'h0042, 2'b00, 16'h0000, 16'h0042, 2'b00, 3'b010, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 1, 6, 6, 6, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 3'b010, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 6, 16'h0000, 16'h0000, 2'b10, 16'h0000, 16'h0000, 2'b10, 3'b010, 1);
    vecs[10] = mk(1, 6, 16'hBEEF, 1, 0, 0, 0, 6, 16'h0000, 16'hBEEF, 2'b00, 16'h0000, 16'h0000, 2'b10, 3'b100, 0);
    vecs[11] = mk(0, 0, 16'h0000, 0, 0, 0, 6, 6, 16'hBEEF, 16'hBEEF, 2'b00, 16'hBEEF, 16'hBEEF, 2'b00, 3'b100, 0);
    vecs[12] = mk(1, 4, 16'h7FFF, 1, 1, 4, 4, 0, 16'h7FFF, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 3'b001, 1);
    vecs[13] = mk(0, 0, 16'h0000, 0, 0, 0, 4, 4, 16'h7FFF, 16'h7FFF, 2'b11, 16'h7FFF, 16'h7FFF, 2'b11, 3'b001, 1);
    vecs[14] = mk(1, 4, 16'h0001, 0, 0, 0, 4, 3, 16'h0001, 16'h8001, 2'b00, 16'h7FFF, 16'h8001, 2'b01, 3'b001, 0);

    // Reset state on every register, both ports, both instances.
    for (int r = 0; r < 8; r++) begin
      rd_sel = {3'(r), 3'(r)};
      #1;
      chk($sformatf("rst rd R%0d", r), 64'(rd_b), 64'h0);
      chk($sformatf("rst nb rd R%0d", r), 64'(rd_n), 64'h0);
      chk($sformatf("rst busy R%0d", r), 64'({busy_b, busy_n}), 64'h0);
    end
    chk("rst nzp", 64'({nzp_b, nzp_n}), 64'({3'b010, 3'b010}));
    chk("rst any", 64'({any_b, any_n}), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      wr_en = v.wr_en; wr_sel = v.wr_sel; wr_data = v.wr_data; ld_cc = v.ld_cc;
      rsv_en = v.rsv_en; rsv_sel = v.rsv_sel; rd_sel = {v.rd1, v.rd0};
      exp_q.push_back('{v.nzp, v.any});
      #3;
      chk($sformatf("v%0d rd", i), 64'(rd_b), 64'({v.b1, v.b0}));
      chk($sformatf("v%0d busy", i), 64'(busy_b), 64'(v.bb));
      chk($sformatf("v%0d nb rd", i), 64'(rd_n), 64'({v.n1, v.n0}));
      chk($sformatf("v%0d nb busy", i), 64'(busy_n), 64'(v.nb));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d nzp", i), 64'({nzp_b, nzp_n}), 64'({e.nzp, e.nzp}));
      chk($sformatf("v%0d any", i), 64'({any_b, any_n}), 64'({e.any, e.any}));
    end
    wr_en = 0; ld_cc = 0; rsv_en = 0;

    // Reservations and an in-flight write are discarded by an asynchronous reset.
    rsv_en = 1; rsv_sel = 3'd1;
    @(posedge clk); #1;
    rsv_sel = 3'd7;
    @(posedge clk); #1;
    rsv_en = 0;
    chk("pre-rst any", 64'({any_b, any_n}), 64'b11);
    wr_en = 1; wr_sel = 3'd2; wr_data = 16'h5555; ld_cc = 1;
    #2 rst = 1'b1;
    #1;
    chk("async rst any", 64'({any_b, any_n}), 64'h0);
    chk("async rst nzp", 64'({nzp_b, nzp_n}), 64'({3'b010, 3'b010}));
    @(posedge clk); #1;
    wr_en = 0; ld_cc = 0;
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rd_sel = {3'(r), 3'(r)};
      #1;
      chk($sformatf("post-rst R%0d", r), 64'({rd_b, rd_n}), 64'h0);
    end
    @(posedge clk); #1;
    chk("post-rst nzp", 64'({nzp_b, nzp_n}), 64'({3'b010, 3'b010}));
    chk("post-rst any", 64'({any_b, any_n}), 64'h0);

    // Wide three-port instance.
    w_wr_en = 1; w_wr_sel = 4'd15; w_wr_data = 32'hFFFF_FFFF; w_ld_cc = 1;
    w_rd_sel = {4'd15, 4'd0, 4'd0};
    #1;
    chk("w bypass p2", 64'(w_rd[95:64]), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    w_wr_en = 0; w_ld_cc = 0;
    chk("w rd p2", 64'(w_rd[95:64]), 64'hFFFF_FFFF);
    chk("w rd p0", 64'(w_rd[31:0]), 64'h0);
    chk("w nzp", 64'(w_nzp), 64'(3'b100));
    w_rsv_en = 1; w_rsv_sel = 4'd15;
    @(posedge clk); #1;
    w_rsv_en = 0;
    chk("w busy", 64'(w_busy), 64'(3'b100));
    chk("w any", 64'(w_any), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
